// File: rtl/axi_serializer_pkg.sv
// Shared types for the word-to-bit AXI-Stream serializer.
package axi_serializer_pkg;

  typedef enum logic {
    StEmpty = 1'b0,
    StShift = 1'b1
  } shift_state_e;

endpackage

// File: rtl/axi_serializer_if.sv
// AXI-Stream bundle for the serializer: WIDTH-bit input stream and 1-bit output stream.
interface axi_serializer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic             o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport slave (
    input  i_tdata,
    input  i_tlast,
    input  i_tvalid,
    output i_tready,
    output o_tdata,
    output o_tlast,
    output o_tvalid,
    input  o_tready
  );

  modport master (
    output i_tdata,
    output i_tlast,
    output i_tvalid,
    input  i_tready,
    input  o_tdata,
    input  o_tlast,
    input  o_tvalid,
    output o_tready
  );

endinterface

// File: rtl/axi_serializer.sv
// WIDTH-bit AXI-Stream to 1-bit AXI-Stream serializer, MSB first, with a one-word holding
// register in front of the shifter so consecutive words leave with no bubble between them.
module axi_serializer
  import axi_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             reverse_input,
  axi_serializer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] rev_data;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] hold_data_q;
  logic             hold_last_q;
  logic             hold_valid_q;
  logic [WIDTH-1:0] shreg_q;
  logic             shift_last_q;
  logic [CNT_W-1:0] cnt_q;
  shift_state_e     state_q;

  logic shift_valid;
  logic in_hs;
  logic out_hs;
  logic last_bit;
  logic load;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bitrev
    assign rev_data[i] = bus.i_tdata[WIDTH-1-i];
  end

  assign cap_data    = reverse_input ? rev_data : bus.i_tdata;
  assign shift_valid = (state_q == StShift);
  assign in_hs       = bus.i_tvalid & ~hold_valid_q;
  assign out_hs      = shift_valid & bus.o_tready;
  assign last_bit    = (cnt_q == '0);
  // Hold is drained either into an idle shifter or on the final bit of the current word.
  assign load        = hold_valid_q & (~shift_valid | (out_hs & last_bit));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
    end else if (in_hs) begin
      // A fresh capture wins over a concurrent drain.
      hold_data_q  <= cap_data;
      hold_last_q  <= bus.i_tlast;
      hold_valid_q <= 1'b1;
    end else if (load) begin
      hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q      <= StEmpty;
      shreg_q      <= '0;
      shift_last_q <= 1'b0;
      cnt_q        <= CNT_MAX;
    end else begin
      case (state_q)
        StEmpty: begin
          if (hold_valid_q) begin
            shreg_q      <= hold_data_q;
            shift_last_q <= hold_last_q;
            cnt_q        <= CNT_MAX;
            state_q      <= StShift;
          end
        end
        StShift: begin
          if (out_hs) begin
            if (!last_bit) begin
              shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
              cnt_q   <= cnt_q - CNT_W'(1);
            end else if (hold_valid_q) begin
              shreg_q      <= hold_data_q;
              shift_last_q <= hold_last_q;
              cnt_q        <= CNT_MAX;
            end else begin
              state_q <= StEmpty;
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign bus.i_tready = ~hold_valid_q;
  assign bus.o_tdata  = shreg_q[WIDTH-1];
  assign bus.o_tvalid = shift_valid;
  assign bus.o_tlast  = shift_valid & shift_last_q & last_bit;

endmodule
